// File: rtl/aes_pkg.sv
// Shared AES byte/state types, FSM encoding and the S-box arithmetic used by the substitution lanes.
// The S-boxes are built from GF(2^8) inversion and the affine map, so no table has to be maintained by hand.
package aes_pkg;

    localparam int BYTE_W      = 8;
    localparam int STATE_BYTES = 16;

    typedef logic [BYTE_W-1:0]               byte_t;
    typedef logic [0:STATE_BYTES*BYTE_W-1]   state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_HOLD
    } fsm_state_t;

    function automatic bit legal_lanes(int lanes);
        return lanes inside {1, 2, 4, 8, 16};
    endfunction

    function automatic byte_t rotl(byte_t x, int n);
        return byte_t'((x << n) | (x >> (BYTE_W - n)));
    endfunction

    function automatic byte_t gf_mul(byte_t a, byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
    function automatic byte_t gf_inv(byte_t a);
        byte_t r;
        byte_t p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic byte_t fwd_sbox(byte_t x);
        byte_t v;
        v = gf_inv(x);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic byte_t inv_sbox(byte_t s);
        return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/sub_bytes_lane.sv
// One substitution lane: synchronous inverse S-box ROM, one cycle from address to data, loads only on rd_en_i.
// With SUBBYTES_FWD_EN a forward ROM sits alongside and mode_i (1 = forward) selects the result.
module sub_bytes_lane
    import aes_pkg::*;
(
    input  logic  clk_i,
    input  logic  rd_en_i,
    input  byte_t addr_i,
`ifdef SUBBYTES_FWD_EN
    input  logic  mode_i,
`endif
    output byte_t data_o
);

    byte_t inv_q;

    always_ff @(posedge clk_i) begin
        if (rd_en_i) inv_q <= inv_sbox(addr_i);
    end

`ifdef SUBBYTES_FWD_EN
    byte_t fwd_q;

    always_ff @(posedge clk_i) begin
        if (rd_en_i) fwd_q <= fwd_sbox(addr_i);
    end

    assign data_o = mode_i ? fwd_q : inv_q;
`else
    assign data_o = inv_q;
`endif

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: LANES bytes per beat, OUT_VALID 16/LANES+2 cycles after acceptance; one state in flight,
// IN_READY only in IDLE and the result is held stable until OUT_READY. SUBBYTES_FWD_EN adds MODE (1 = forward S-box).
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int STATE_W = 128
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [0:STATE_W-1] IN_STATE,
`ifdef SUBBYTES_FWD_EN
    input  logic               MODE,
`endif
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [0:STATE_W-1] OUT_STATE,
    output logic               BUSY
);

    localparam int N  = STATE_BYTES / LANES;
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    if (!legal_lanes(LANES)) begin : g_bad_lanes
        $error("inv_sub_bytes_iter: LANES=%0d is not one of 1,2,4,8,16", LANES);
    end
    if (STATE_W != STATE_BYTES * BYTE_W) begin : g_bad_width
        $error("inv_sub_bytes_iter: STATE_W=%0d must be 128", STATE_W);
    end

    fsm_state_t      state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [BW-1:0]   wr_beat_q;
    logic            wr_vld_q;
    logic            rd_en;
    state_t          in_q;
    state_t          out_q;
    byte_t           rom_addr [LANES];
    byte_t           lane_dat [LANES];
`ifdef SUBBYTES_FWD_EN
    logic            mode_q;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    state_d = ST_ISSUE;
                    beat_d  = '0;
                end
            end
            ST_ISSUE: begin
                rd_en = 1'b1;
                if (beat_q == BW'(N - 1)) state_d = ST_DRAIN;
                else                      beat_d  = beat_q + BW'(1);
            end
            ST_DRAIN: state_d = ST_HOLD;
            ST_HOLD:  if (OUT_READY) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rom_addr[l] = in_q[(int'(beat_q) * LANES + l) * BYTE_W +: BYTE_W];
        end
    end

    // ROM data trails its address by one cycle, so the write slot is the previous beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            wr_beat_q <= '0;
            wr_vld_q  <= 1'b0;
            in_q      <= '0;
            out_q     <= '0;
`ifdef SUBBYTES_FWD_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wr_beat_q <= beat_q;
            wr_vld_q  <= rd_en;
            if (state_q == ST_IDLE && IN_VALID) begin
                in_q   <= IN_STATE;
`ifdef SUBBYTES_FWD_EN
                mode_q <= MODE;
`endif
            end
            if (wr_vld_q) begin
                for (int l = 0; l < LANES; l++) begin
                    out_q[(int'(wr_beat_q) * LANES + l) * BYTE_W +: BYTE_W] <= lane_dat[l];
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sub_bytes_lane u_lane (
            .clk_i   (CLK),
            .rd_en_i (rd_en),
            .addr_i  (rom_addr[l]),
`ifdef SUBBYTES_FWD_EN
            .mode_i  (mode_q),
`endif
            .data_o  (lane_dat[l])
        );
    end

    assign IN_READY  = (state_q == ST_IDLE) && !RST;
    assign OUT_VALID = (state_q == ST_HOLD);
    assign OUT_STATE = out_q;
    assign BUSY      = (state_q != ST_IDLE);

endmodule
